// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer.
package debounce_pkg;

    // Stability-check FSM states
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } db_state_t;

    // Width of the optional aborted-check counter
    localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Asynchronous active-low reset clears every stage to 0.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic q_sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw level one stage deeper each cycle
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_async};
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_sync = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Button/switch debouncer: synchronises btn_in, then accepts a new level only
// after DEBOUNCE_CYCLES consecutive stable samples. Outputs a registered level
// plus one-cycle rise/fall pulses aligned with the level change.
// Optional build macro INPUT_DEBOUNCER_GLITCH_CNT_EN adds a saturating 8-bit
// count of aborted stability checks on port glitch_cnt.
//
// Handshake note: there is no valid/ready pair; level_out is always valid and
// rise_pulse/fall_pulse are single-cycle qualifiers of a level change.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // A single stable sample is enough: skip the CHK states entirely
    localparam bit ONE_SHOT = (DEBOUNCE_CYCLES == 1);

    logic s;

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .d_async (btn_in),
        .q_sync  (s)
    );

    // Next-state logic: count stable samples, abort on any toggle
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    if (ONE_SHOT) begin
                        state_d = IDLE_HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        count_d = '0;
                    end else begin
                        state_d = CHK_HIGH;
                        count_d = CNT_ONE;
                    end
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    if (ONE_SHOT) begin
                        state_d = IDLE_LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        count_d = '0;
                    end else begin
                        state_d = CHK_LOW;
                        count_d = CNT_ONE;
                    end
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                count_d = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE_LOW;
            count_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic                    aborted;
    logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

    // A check is aborted when the sampled level flips back mid-check
    always_comb begin
        aborted  = ((state_q == CHK_HIGH) && !s) || ((state_q == CHK_LOW) && s);
        glitch_d = glitch_q;
        if (aborted && (glitch_q != '1)) begin
            glitch_d = glitch_q + GLITCH_CNT_W'(1);
        end
    end

    // Saturating aborted-check counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed vectors, expected pulses queued with the
// edge number at which they must appear, checked by an independent monitor.
// Two instances: SYNC_STAGES=2 with DEBOUNCE_CYCLES=8 and with DEBOUNCE_CYCLES=1.
module tb_input_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn1;
    logic level_out, rise_pulse, fall_pulse;
    logic level1, rise1, fall1;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
    logic [7:0] glitch1;
`endif

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    // Expected pulse: {is_rise, edge number}
    logic [16:0] exp_q[$];
    logic [16:0] exp1_q[$];

    input_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    input_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn1),
        .level_out  (level1),
        .rise_pulse (rise1),
        .fall_pulse (fall1)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch1)
`endif
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    // Return 1 time unit after clock edge number k
    task automatic wait_edge(input int k);
        while (edge_cnt < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every pulse must match the head of the expected queue
    always @(negedge clk) begin
        logic [16:0] e;
        if (rise_pulse || fall_pulse) begin
            check("dut single pulse", {31'd0, rise_pulse & fall_pulse}, 32'd0);
            check("dut pulse level", {31'd0, level_out}, {31'd0, rise_pulse});
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut pulse: unexpected rise=%0b fall=%0b at edge %0d",
                         rise_pulse, fall_pulse, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                check("dut pulse", {15'd0, rise_pulse, edge_cnt[15:0]}, {15'd0, e});
            end
        end
        if (rise1 || fall1) begin
            check("dut1 single pulse", {31'd0, rise1 & fall1}, 32'd0);
            if (exp1_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1 pulse: unexpected rise=%0b fall=%0b at edge %0d",
                         rise1, fall1, edge_cnt);
            end else begin
                e = exp1_q.pop_front();
                check("dut1 pulse", {15'd0, rise1, edge_cnt[15:0]}, {15'd0, e});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        reset  = 1'b0;
        btn_in = 1'b0;
        btn1   = 1'b0;

        // Reset state
        wait_edge(2);
        check("reset level", {31'd0, level_out}, 32'd0);
        check("reset rise", {31'd0, rise_pulse}, 32'd0);
        check("reset fall", {31'd0, fall_pulse}, 32'd0);
        check("reset level1", {31'd0, level1}, 32'd0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("reset glitch", {24'd0, glitch_cnt}, 32'd0);
`endif
        reset = 1'b1;

        // Clean step: change after edge 10 -> accepted at edge 10+2+8
        wait_edge(10);
        btn_in = 1'b1;
        exp_q.push_back({1'b1, 16'd20});
        wait_edge(19);
        check("step level early", {31'd0, level_out}, 32'd0);
        wait_edge(20);
        check("step level", {31'd0, level_out}, 32'd1);
        check("step rise", {31'd0, rise_pulse}, 32'd1);
        wait_edge(21);
        check("step rise end", {31'd0, rise_pulse}, 32'd0);
        check("step level hold", {31'd0, level_out}, 32'd1);

        // Release: change after edge 40 -> accepted at edge 50
        wait_edge(40);
        btn_in = 1'b0;
        exp_q.push_back({1'b0, 16'd50});
        wait_edge(49);
        check("release level early", {31'd0, level_out}, 32'd1);
        wait_edge(50);
        check("release level", {31'd0, level_out}, 32'd0);
        check("release fall", {31'd0, fall_pulse}, 32'd1);
        wait_edge(51);
        check("release fall end", {31'd0, fall_pulse}, 32'd0);

        // Bounce: high 5, low 1, high 3, low -> two aborted checks, no pulse
        wait_edge(60); btn_in = 1'b1;
        wait_edge(65); btn_in = 1'b0;
        wait_edge(66); btn_in = 1'b1;
        wait_edge(69); btn_in = 1'b0;
        wait_edge(90);
        check("bounce level", {31'd0, level_out}, 32'd0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("bounce glitch", {24'd0, glitch_cnt}, 32'd2);
`endif

        // Reset mid-check: FSM has seen 3 high samples by edge 105
        wait_edge(100); btn_in = 1'b1;
        wait_edge(105);
        reset = 1'b0;
        #1;
        check("midchk level", {31'd0, level_out}, 32'd0);
        check("midchk rise", {31'd0, rise_pulse}, 32'd0);
        check("midchk fall", {31'd0, fall_pulse}, 32'd0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("midchk glitch", {24'd0, glitch_cnt}, 32'd0);
`endif
        wait_edge(107);
        reset = 1'b1;
        // Edge 108 is the first with reset=1 and loads stage 1; counting it
        // as the 1st edge, the 10th edge (117) accepts the level.
        exp_q.push_back({1'b1, 16'd117});
        wait_edge(116);
        check("midchk level early", {31'd0, level_out}, 32'd0);
        wait_edge(117);
        check("midchk level rise", {31'd0, level_out}, 32'd1);

        // Asynchronous reset while level is high, between clock edges
        wait_edge(120);
        #2;
        reset = 1'b0;
        #1;
        check("async reset level", {31'd0, level_out}, 32'd0);
        btn_in = 1'b0;
        wait_edge(122);
        reset = 1'b1;

        // DEBOUNCE_CYCLES=1: one-cycle pulse after edge 130 -> level high at 133 only
        wait_edge(130);
        btn1 = 1'b1;
        exp1_q.push_back({1'b1, 16'd133});
        exp1_q.push_back({1'b0, 16'd134});
        wait_edge(131);
        btn1 = 1'b0;
        wait_edge(132);
        check("one level early", {31'd0, level1}, 32'd0);
        wait_edge(133);
        check("one level high", {31'd0, level1}, 32'd1);
        wait_edge(134);
        check("one level low", {31'd0, level1}, 32'd0);

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        // 300 aborted checks: one high sample then one low sample each
        wait_edge(140);
        for (int i = 0; i < 300; i++) begin
            btn_in = 1'b1;
            wait_edge(edge_cnt + 1);
            btn_in = 1'b0;
            wait_edge(edge_cnt + 1);
        end
        wait_edge(edge_cnt + 5);
        check("sat glitch", {24'd0, glitch_cnt}, 32'd255);
        check("sat level", {31'd0, level_out}, 32'd0);
`endif

        wait_edge(edge_cnt + 5);
        check("dut queue drained", exp_q.size(), 32'd0);
        check("dut1 queue drained", exp1_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
